// File: rtl/rab_pkg.sv
// Shared types and helpers for the RAB range-invalidation sequencer.
// Index and counter widths depend on instance parameters, so they are derived through functions here.
package rab_pkg;

  typedef enum logic [2:0] {
    INV_IDLE    = 3'd0,
    INV_L1_SCAN = 3'd1,
    INV_L2_RD   = 3'd2,
    INV_L2_CHK  = 3'd3,
    INV_DONE    = 3'd4
  } inv_state_e;

  // Widest compare supported: AW+1 must not exceed this.
  localparam int RAB_CMP_W = 64;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int inv_cntw(input int n_slices, input int n_l2);
    return $clog2(n_slices + n_l2 + 1);
  endfunction

  // Inclusive overlap of [first,last] with [lo,hi], unsigned.
  function automatic logic range_overlap(input logic [RAB_CMP_W-1:0] first_addr,
                                         input logic [RAB_CMP_W-1:0] last_addr,
                                         input logic [RAB_CMP_W-1:0] lo,
                                         input logic [RAB_CMP_W-1:0] hi);
    return (first_addr <= hi) && (last_addr >= lo);
  endfunction

endpackage

// File: rtl/rab_inv_sequencer_if.sv
// Bundle between the sequencer, the config regfile and the L1/L2 translation tables.
// slave = sequencer view, master = regfile/table side.
interface rab_inv_sequencer_if #(
  parameter int AW           = 32,
  parameter int N_SLICES     = 16,
  parameter int N_L2_SETS    = 32,
  parameter int N_L2_ENTRIES = 4,
  parameter int PAGE_BITS    = 12
) ();
  localparam int N_L2 = N_L2_SETS * N_L2_ENTRIES;
  localparam int L1W  = rab_pkg::idx_w(N_SLICES);
  localparam int L2W  = rab_pkg::idx_w(N_L2);
  localparam int CNTW = rab_pkg::inv_cntw(N_SLICES, N_L2);

  logic                  inv_start_i;
  logic [AW-1:0]         inv_lo_i;
  logic [AW-1:0]         inv_hi_i;
  logic                  busy_o;
  logic                  done_o;
  logic [CNTW-1:0]       inv_cnt_o;
  logic [L1W-1:0]        l1_idx_o;
  logic [AW-1:0]         l1_first_i;
  logic [AW-1:0]         l1_last_i;
  logic                  l1_valid_i;
  logic                  l1_clr_o;
  logic                  l2_req_o;
  logic [L2W-1:0]        l2_addr_o;
  logic [AW-PAGE_BITS-1:0] l2_va_i;
  logic                  l2_valid_i;
  logic                  l2_clr_o;

  modport slave (
    input  inv_start_i, inv_lo_i, inv_hi_i,
    input  l1_first_i, l1_last_i, l1_valid_i,
    input  l2_va_i, l2_valid_i,
    output busy_o, done_o, inv_cnt_o,
    output l1_idx_o, l1_clr_o,
    output l2_req_o, l2_addr_o, l2_clr_o
  );

  modport master (
    output inv_start_i, inv_lo_i, inv_hi_i,
    output l1_first_i, l1_last_i, l1_valid_i,
    output l2_va_i, l2_valid_i,
    input  busy_o, done_o, inv_cnt_o,
    input  l1_idx_o, l1_clr_o,
    input  l2_req_o, l2_addr_o, l2_clr_o
  );
endinterface

// File: rtl/rab_range_cmp.sv
// Inclusive unsigned overlap test between an entry span and the invalidation range.
// Entry bounds are AW+1 bits wide so a page end at the top of the address space cannot wrap.
module rab_range_cmp
  import rab_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic [AW:0]   first_addr,
  input  logic [AW:0]   last_addr,
  input  logic [AW-1:0] lo,
  input  logic [AW-1:0] hi,
  output logic          hit
);
  assign hit = range_overlap(RAB_CMP_W'(first_addr), RAB_CMP_W'(last_addr),
                             RAB_CMP_W'(lo), RAB_CMP_W'(hi));
endmodule

// File: rtl/rab_inv_sequencer.sv
// Walks every L1 slice, then every L2 TLB entry, clearing valid bits of mappings that overlap
// the registered [lo,hi] range; busy blocks config writes for the whole run.
module rab_inv_sequencer
  import rab_pkg::*;
#(
  parameter int AW           = 32,
  parameter int N_SLICES     = 16,
  parameter int N_L2_SETS    = 32,
  parameter int N_L2_ENTRIES = 4,
  parameter int PAGE_BITS    = 12
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  rab_inv_sequencer_if.slave      bus
);
  localparam int N_L2 = N_L2_SETS * N_L2_ENTRIES;
  localparam int L1W  = idx_w(N_SLICES);
  localparam int L2W  = idx_w(N_L2);
  localparam int CNTW = inv_cntw(N_SLICES, N_L2);

  localparam logic [2:0] ST_IDLE    = 3'(INV_IDLE);
  localparam logic [2:0] ST_L1_SCAN = 3'(INV_L1_SCAN);
  localparam logic [2:0] ST_L2_RD   = 3'(INV_L2_RD);
  localparam logic [2:0] ST_L2_CHK  = 3'(INV_L2_CHK);
  localparam logic [2:0] ST_DONE    = 3'(INV_DONE);

  localparam logic [L1W-1:0] L1_LAST   = L1W'(N_SLICES - 1);
  localparam logic [L2W-1:0] L2_LAST   = L2W'(N_L2 - 1);
  localparam logic [AW:0]    PAGE_SPAN = (AW+1)'((64'd1 << PAGE_BITS) - 64'd1);

  logic [2:0]      state_reg;
  logic [AW-1:0]   lo_reg;
  logic [AW-1:0]   hi_reg;
  logic [L1W-1:0]  l1_idx_reg;
  logic [L2W-1:0]  l2_idx_reg;
  logic [CNTW-1:0] cnt_reg;

  logic            l1_hit;
  logic            l2_hit;
  logic            l1_clr;
  logic            l2_clr;
  logic [AW:0]     l2_page_first;
  logic [AW:0]     l2_page_last;

  assign l2_page_first = {1'b0, bus.l2_va_i, {PAGE_BITS{1'b0}}};
  assign l2_page_last  = l2_page_first + PAGE_SPAN;

  rab_range_cmp #(.AW(AW)) u_l1_cmp (
    .first_addr ({1'b0, bus.l1_first_i}),
    .last_addr  ({1'b0, bus.l1_last_i}),
    .lo         (lo_reg),
    .hi         (hi_reg),
    .hit        (l1_hit)
  );

  rab_range_cmp #(.AW(AW)) u_l2_cmp (
    .first_addr (l2_page_first),
    .last_addr  (l2_page_last),
    .lo         (lo_reg),
    .hi         (hi_reg),
    .hit        (l2_hit)
  );

  // Clears are gated by state so IDLE/DONE can never touch the tables.
  assign l1_clr = (state_reg == ST_L1_SCAN) && bus.l1_valid_i && l1_hit;
  assign l2_clr = (state_reg == ST_L2_CHK)  && bus.l2_valid_i && l2_hit;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg  <= ST_IDLE;
      lo_reg     <= '0;
      hi_reg     <= '0;
      l1_idx_reg <= '0;
      l2_idx_reg <= '0;
      cnt_reg    <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (bus.inv_start_i) begin
            lo_reg     <= bus.inv_lo_i;
            hi_reg     <= bus.inv_hi_i;
            cnt_reg    <= '0;
            l1_idx_reg <= '0;
            l2_idx_reg <= '0;
            state_reg  <= (bus.inv_hi_i < bus.inv_lo_i) ? ST_DONE : ST_L1_SCAN;
          end
        end
        ST_L1_SCAN: begin
          if (l1_clr) cnt_reg <= cnt_reg + CNTW'(1);
          if (l1_idx_reg == L1_LAST) begin
            l1_idx_reg <= '0;
            l2_idx_reg <= '0;
            state_reg  <= ST_L2_RD;
          end else begin
            l1_idx_reg <= l1_idx_reg + L1W'(1);
          end
        end
        ST_L2_RD: begin
          state_reg <= ST_L2_CHK;
        end
        ST_L2_CHK: begin
          if (l2_clr) cnt_reg <= cnt_reg + CNTW'(1);
          if (l2_idx_reg == L2_LAST) begin
            l2_idx_reg <= '0;
            state_reg  <= ST_DONE;
          end else begin
            l2_idx_reg <= l2_idx_reg + L2W'(1);
            state_reg  <= ST_L2_RD;
          end
        end
        ST_DONE: begin
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy_o    = (state_reg != ST_IDLE);
  assign bus.done_o    = (state_reg == ST_DONE);
  assign bus.inv_cnt_o = cnt_reg;
  assign bus.l1_idx_o  = l1_idx_reg;
  assign bus.l1_clr_o  = l1_clr;
  assign bus.l2_req_o  = (state_reg == ST_L2_RD);
  assign bus.l2_addr_o = l2_idx_reg;
  assign bus.l2_clr_o  = l2_clr;

endmodule

// File: tb/tb_rab_inv_sequencer.sv
// Directed bench for rab_inv_sequencer: table of range vectors plus hand-written
// sequences for dropped/back-to-back starts and a reset in the middle of the L2 scan.
module tb_rab_inv_sequencer;
  localparam int AW    = 32;
  localparam int NS    = 4;
  localparam int NSETS = 2;
  localparam int NENT  = 2;
  localparam int PB    = 12;
  localparam int NL2   = NSETS * NENT;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rab_inv_sequencer_if #(.AW(AW), .N_SLICES(NS), .N_L2_SETS(NSETS),
                         .N_L2_ENTRIES(NENT), .PAGE_BITS(PB)) bus ();

  rab_inv_sequencer #(.AW(AW), .N_SLICES(NS), .N_L2_SETS(NSETS),
                      .N_L2_ENTRIES(NENT), .PAGE_BITS(PB)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  // Table model: slice i spans [i*0x1000, i*0x1000+0xFFF]; L2 entry j holds page base+j.
  logic [31:0] sl_first [NS];
  logic [31:0] sl_last  [NS];
  logic        sl_valid [NS];
  logic [19:0] l2_va    [NL2];
  logic        l2_v     [NL2];
  logic [19:0] l2_va_q;
  logic        l2_v_q;

  logic        load;
  logic [3:0]  load_l1v;
  logic [19:0] load_base;

  assign bus.l1_first_i = sl_first[bus.l1_idx_o];
  assign bus.l1_last_i  = sl_last[bus.l1_idx_o];
  assign bus.l1_valid_i = sl_valid[bus.l1_idx_o];
  assign bus.l2_va_i    = l2_va_q;
  assign bus.l2_valid_i = l2_v_q;

  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < NS; i++) begin
        sl_first[i] <= 32'(i) * 32'h1000;
        sl_last[i]  <= 32'(i) * 32'h1000 + 32'hFFF;
        sl_valid[i] <= load_l1v[i];
      end
      for (int j = 0; j < NL2; j++) begin
        l2_va[j] <= load_base + 20'(j);
        l2_v[j]  <= 1'b1;
      end
    end else begin
      if (bus.l1_clr_o) sl_valid[bus.l1_idx_o] <= 1'b0;
      if (bus.l2_clr_o) l2_v[bus.l2_addr_o] <= 1'b0;
      if (bus.l2_req_o) begin
        l2_va_q <= l2_va[bus.l2_addr_o];
        l2_v_q  <= l2_v[bus.l2_addr_o];
      end
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge; tables are loaded at the following posedge.
  task automatic setup(input logic [3:0] l1v, input logic [19:0] base);
    load_l1v  = l1v;
    load_base = base;
    load      = 1'b1;
    @(negedge clk);
    load      = 1'b0;
  endtask

  // Called at a negedge: pulses start in cycle 0 and watches up to done_o.
  // inject>0 pulses a second start in that cycle of the run.
  task automatic run_vec(input logic [31:0] lo, input logic [31:0] hi, input int inject,
                         output int lat, output int busy_n, output int dbl,
                         output logic [3:0] l1m, output logic [3:0] l2m);
    lat = 0; busy_n = 0; dbl = 0; l1m = '0; l2m = '0;
    bus.inv_lo_i    = lo;
    bus.inv_hi_i    = hi;
    bus.inv_start_i = 1'b1;
    for (int cyc = 1; cyc <= 60 && lat == 0; cyc++) begin
      @(negedge clk);
      bus.inv_start_i = (cyc == inject);
      if (bus.busy_o) busy_n++;
      if (bus.l1_clr_o) l1m[bus.l1_idx_o] = 1'b1;
      if (bus.l2_clr_o) l2m[bus.l2_addr_o] = 1'b1;
      if (bus.l1_clr_o && bus.l2_clr_o) dbl++;
      if (bus.done_o) lat = cyc;
    end
    bus.inv_start_i = 1'b0;
  endtask

  // One cycle after done_o: sequencer idle, no pulse, count held.
  task automatic post(input string tag, input int exp_cnt);
    @(negedge clk);
    chk({tag, "_idle_busy"}, 64'(bus.busy_o), 64'd0);
    chk({tag, "_idle_done"}, 64'(bus.done_o), 64'd0);
    chk({tag, "_idle_clr"}, 64'(bus.l1_clr_o | bus.l2_clr_o), 64'd0);
    chk({tag, "_cnt"}, 64'(bus.inv_cnt_o), 64'(exp_cnt));
  endtask

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic [3:0]  l1v;
    logic [19:0] l2base;
    logic [3:0]  e_l1;
    logic [3:0]  e_l2;
    int          e_cnt;
    int          e_lat;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int lat, busy_n, dbl;
    logic [3:0] l1m, l2m;
    string tag;

    vecs[0] = '{32'h0000_0000, 32'h0000_7FFF, 4'hF, 20'h00004, 4'hF, 4'hF, 8, 13};
    vecs[1] = '{32'h0000_1800, 32'h0000_4000, 4'hF, 20'h00004, 4'hE, 4'h1, 4, 13};
    vecs[2] = '{32'h0000_0000, 32'h0000_FFFF, 4'hB, 20'h00004, 4'hB, 4'hF, 7, 13};
    vecs[3] = '{32'h0000_2000, 32'h0000_1000, 4'hF, 20'h00004, 4'h0, 4'h0, 0, 1};
    vecs[4] = '{32'h0000_3FFF, 32'h0000_3FFF, 4'hF, 20'h00004, 4'h8, 4'h0, 1, 13};
    vecs[5] = '{32'h0000_7FFF, 32'hFFFF_FFFF, 4'hF, 20'h00004, 4'h0, 4'h8, 1, 13};
    vecs[6] = '{32'h0000_4FFF, 32'h0000_5000, 4'hF, 20'h00004, 4'h0, 4'h3, 2, 13};
    vecs[7] = '{32'h0000_0000, 32'h0000_0000, 4'hF, 20'h00004, 4'h1, 4'h0, 1, 13};
    vecs[8] = '{32'hFFFF_F000, 32'hFFFF_FFFF, 4'hF, 20'hFFFFC, 4'h0, 4'h8, 1, 13};

    load = 1'b0; load_l1v = '0; load_base = '0;
    bus.inv_start_i = 1'b0; bus.inv_lo_i = '0; bus.inv_hi_i = '0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(bus.busy_o), 64'd0);
    chk("rst_done", 64'(bus.done_o), 64'd0);
    chk("rst_l1_clr", 64'(bus.l1_clr_o), 64'd0);
    chk("rst_l2_req", 64'(bus.l2_req_o), 64'd0);
    chk("rst_l2_clr", 64'(bus.l2_clr_o), 64'd0);
    chk("rst_cnt", 64'(bus.inv_cnt_o), 64'd0);
    chk("rst_idx", 64'({bus.l1_idx_o, bus.l2_addr_o}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 9; v++) begin
      tag = $sformatf("vec%0d", v);
      setup(vecs[v].l1v, vecs[v].l2base);
      run_vec(vecs[v].lo, vecs[v].hi, 0, lat, busy_n, dbl, l1m, l2m);
      $display("vec %0d lo=%h hi=%h lat=%0d l1=%h l2=%h cnt=%0d",
               v, vecs[v].lo, vecs[v].hi, lat, l1m, l2m, bus.inv_cnt_o);
      chk({tag, "_latency"}, 64'(lat), 64'(vecs[v].e_lat));
      chk({tag, "_busy_cycles"}, 64'(busy_n), 64'(vecs[v].e_lat));
      chk({tag, "_l1_clears"}, 64'(l1m), 64'(vecs[v].e_l1));
      chk({tag, "_l2_clears"}, 64'(l2m), 64'(vecs[v].e_l2));
      chk({tag, "_double_clr"}, 64'(dbl), 64'd0);
      post(tag, vecs[v].e_cnt);
    end

    // Second start mid-L2 scan is dropped, then a start the cycle after done runs again
    setup(4'hF, 20'h00004);
    run_vec(32'h0, 32'h7FFF, 8, lat, busy_n, dbl, l1m, l2m);
    $display("busy-start run lat=%0d l1=%h l2=%h", lat, l1m, l2m);
    chk("drop_latency", 64'(lat), 64'd13);
    chk("drop_l2_clears", 64'(l2m), 64'hF);
    post("drop", 8);
    run_vec(32'h0, 32'h7FFF, 0, lat, busy_n, dbl, l1m, l2m);
    $display("back-to-back run lat=%0d l1=%h l2=%h cnt=%0d", lat, l1m, l2m, bus.inv_cnt_o);
    chk("b2b_latency", 64'(lat), 64'd13);
    chk("b2b_l1_clears", 64'(l1m), 64'h0);
    post("b2b", 0);

    // Reset during L2_CHK of entry 0 (cycle 6)
    setup(4'hF, 20'h00004);
    bus.inv_lo_i = 32'h0; bus.inv_hi_i = 32'h7FFF; bus.inv_start_i = 1'b1;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(negedge clk);
      bus.inv_start_i = 1'b0;
    end
    chk("mid_l2_clr", 64'(bus.l2_clr_o), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(bus.busy_o), 64'd0);
    chk("arst_l2_clr", 64'(bus.l2_clr_o), 64'd0);
    chk("arst_cnt", 64'(bus.inv_cnt_o), 64'd0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("arst_no_done", 64'(bus.done_o), 64'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    // Slices cleared before reset stay cleared; L2 entry 0 was never written.
    run_vec(32'h0, 32'h7FFF, 0, lat, busy_n, dbl, l1m, l2m);
    $display("post-reset run lat=%0d l1=%h l2=%h", lat, l1m, l2m);
    chk("rerun_latency", 64'(lat), 64'd13);
    chk("rerun_l1_clears", 64'(l1m), 64'h0);
    chk("rerun_l2_clears", 64'(l2m), 64'hF);
    post("rerun", 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
